// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one shared full-adder cell is stepped LSB-first, one bit per clock,
// with operands and result moved over valid/ready handshakes.

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module full_adder_using_half_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
   half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

   assign cout = c1 | c2;
endmodule

module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;
   logic             cell_s;
   logic             cell_c;
   logic [WIDTH-1:0] sum_shift;

   full_adder_using_half_adder u_cell (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .cin (carry),
      .s   (cell_s),
      .cout(cell_c)
   );

   // Sum bits enter at the MSB so that after WIDTH steps bit 0 has reached position 0.
   generate
      if (WIDTH == 1) begin : g_sum_one
         assign sum_shift = cell_s;
      end else begin : g_sum_many
         assign sum_shift = {cell_s, sum_r[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh   <= A;
                  b_sh   <= B;
                  carry  <= Cin;
                  cnt    <= '0;
                  sum_r  <= '0;
                  cout_r <= 1'b0;
                  ovf_r  <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               sum_r <= sum_shift;
               carry <= cell_c;
               cnt   <= cnt + CW'(1);
               // On the MSB step the carry flop still holds the carry into the MSB.
               if (cnt == LAST) begin
                  cout_r <= cell_c;
                  ovf_r  <= carry ^ cell_c;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign Sum       = sum_r;
   assign Cout      = cout_r;
   assign Ovf       = ovf_r;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer at WIDTH 8, 1 and 16 against an arithmetic
// reference model; only the DUT selected by 'sel' sees handshake activity.

module tb_serial_add_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        cin;
   logic [15:0] a_in;
   logic [15:0] b_in;
   int          sel;

   int tests_run    = 0;
   int tests_failed = 0;

   logic       r8, v8, co8, ov8, bz8;
   logic [7:0] s8;
   logic       r1, v1, co1, ov1, bz1;
   logic [0:0] s1;
   logic       r16, v16, co16, ov16, bz16;
   logic [15:0] s16;

   logic        obs_ready, obs_valid, obs_cout, obs_ovf, obs_busy;
   logic [15:0] obs_sum;

   initial forever #5 clk = ~clk;

   serial_add_sequencer #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel == 8), .in_ready(r8),
      .A(a_in[7:0]), .B(b_in[7:0]), .Cin(cin), .out_valid(v8),
      .out_ready(out_ready && sel == 8), .Sum(s8), .Cout(co8), .Ovf(ov8), .busy(bz8)
   );

   serial_add_sequencer #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(r1),
      .A(a_in[0:0]), .B(b_in[0:0]), .Cin(cin), .out_valid(v1),
      .out_ready(out_ready && sel == 1), .Sum(s1), .Cout(co1), .Ovf(ov1), .busy(bz1)
   );

   serial_add_sequencer #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel == 16), .in_ready(r16),
      .A(a_in), .B(b_in), .Cin(cin), .out_valid(v16),
      .out_ready(out_ready && sel == 16), .Sum(s16), .Cout(co16), .Ovf(ov16), .busy(bz16)
   );

   always_comb begin
      obs_ready = r8;
      obs_valid = v8;
      obs_cout  = co8;
      obs_ovf   = ov8;
      obs_busy  = bz8;
      obs_sum   = {8'h00, s8};
      if (sel == 1) begin
         obs_ready = r1;
         obs_valid = v1;
         obs_cout  = co1;
         obs_ovf   = ov1;
         obs_busy  = bz1;
         obs_sum   = {15'h0000, s1};
      end else if (sel == 16) begin
         obs_ready = r16;
         obs_valid = v16;
         obs_cout  = co16;
         obs_ovf   = ov16;
         obs_busy  = bz16;
         obs_sum   = s16;
      end
   end

   // Reference: {Ovf, Cout, Sum} from plain integer addition and two's-complement sign rules.
   function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
      logic [16:0] mask;
      logic [16:0] am, bm, full, sm;
      logic        co, ov;
      mask = (17'd1 << w) - 17'd1;
      am   = {1'b0, a} & mask;
      bm   = {1'b0, b} & mask;
      full = am + bm + {16'd0, c};
      sm   = full & mask;
      co   = full[w];
      ov   = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
      return {ov, co, sm[15:0]};
   endfunction

   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
      int g;
      @(negedge clk);
      a_in     = a;
      b_in     = b;
      cin      = c;
      in_valid = 1'b1;
      g = 0;
      while (!obs_ready && g < 64) begin
         @(negedge clk);
         g++;
      end
      tests_run++;
      if (g >= 64) begin
         tests_failed++;
         $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", obs_ready, g);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int edges);
      edges = 0;
      while (!obs_valid && edges < 64) begin
         @(negedge clk);
         edges++;
      end
      tests_run++;
      if (!obs_valid) begin
         tests_failed++;
         $display("[TB] FAIL result_timeout: out_valid=%b after %0d cycles, required 1", obs_valid, edges);
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      sel = 8;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tests_run += 6;
      if (obs_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b want 1", obs_ready); end
      if (obs_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b want 0", obs_valid); end
      if (obs_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", obs_busy); end
      if (obs_sum !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_sum: got %h want 00", obs_sum); end
      if (obs_cout !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cout: got %b want 0", obs_cout); end
      if (obs_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ovf: got %b want 0", obs_ovf); end
   endtask

   task automatic test_basic_and_wrap();
      logic [15:0] ta [3] = '{16'h005A, 16'h00FF, 16'h00FF};
      logic [15:0] tb [3] = '{16'h003C, 16'h0001, 16'h00FF};
      logic        tc [3] = '{1'b0, 1'b0, 1'b1};
      logic [7:0]  es [3] = '{8'h96, 8'h00, 8'hFF};
      logic        ec [3] = '{1'b0, 1'b1, 1'b1};
      logic        eo [3] = '{1'b1, 1'b0, 1'b0};
      int edges;
      sel = 8;
      for (int i = 0; i < 3; i++) begin
         start_op(ta[i], tb[i], tc[i]);
         wait_valid(edges);
         tests_run += 5;
         if (edges !== 8) begin tests_failed++; $display("[TB] FAIL latency_%0d: got %0d cycles want 8", i, edges + 0); end
         if (obs_sum !== {8'h00, es[i]}) begin tests_failed++; $display("[TB] FAIL sum_%0d: got %h want %h", i, obs_sum, es[i]); end
         if (obs_cout !== ec[i]) begin tests_failed++; $display("[TB] FAIL cout_%0d: got %b want %b", i, obs_cout, ec[i]); end
         if (obs_ovf !== eo[i]) begin tests_failed++; $display("[TB] FAIL ovf_%0d: got %b want %b", i, obs_ovf, eo[i]); end
         if (obs_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL busy_done_%0d: got %b want 1", i, obs_busy); end
         release_result();
      end
   endtask

   task automatic test_backpressure();
      int edges;
      sel = 8;
      start_op(16'h0064, 16'h00C8, 1'b1);
      wait_valid(edges);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         a_in     = 16'h0077;
         b_in     = 16'h0011;
         cin      = 1'b0;
         @(negedge clk);
         tests_run += 4;
         if (obs_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_valid_%0d: got %b want 1", k, obs_valid); end
         if (obs_sum !== 16'h002D) begin tests_failed++; $display("[TB] FAIL hold_sum_%0d: got %h want 2d", k, obs_sum); end
         if (obs_cout !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_cout_%0d: got %b want 1", k, obs_cout); end
         if (obs_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_in_ready_%0d: got %b want 0", k, obs_ready); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      tests_run += 2;
      if (obs_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_release_in_ready: got %b want 1", obs_ready); end
      if (obs_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_release_out_valid: got %b want 0", obs_valid); end
      @(negedge clk);
      tests_run++;
      if (obs_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ignored_ops_busy: got %b want 0", obs_busy); end
   endtask

   task automatic test_reset_mid_run();
      int edges;
      sel = 8;
      start_op(16'h00F0, 16'h000F, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run += 4;
      if (obs_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_in_ready: got %b want 1", obs_ready); end
      if (obs_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_busy: got %b want 0", obs_busy); end
      if (obs_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_out_valid: got %b want 0", obs_valid); end
      if ({obs_sum, obs_cout, obs_ovf} !== 18'h0) begin
         tests_failed++;
         $display("[TB] FAIL midrst_result: got sum=%h cout=%b ovf=%b want zeros", obs_sum, obs_cout, obs_ovf);
      end
      start_op(16'h0001, 16'h0001, 1'b0);
      wait_valid(edges);
      tests_run++;
      if ({obs_ovf, obs_cout, obs_sum} !== {2'b00, 16'h0002}) begin
         tests_failed++;
         $display("[TB] FAIL after_rst_sum: got sum=%h cout=%b ovf=%b want 02/0/0", obs_sum, obs_cout, obs_ovf);
      end
      release_result();
   endtask

   // Scoreboard: at most one op in flight; 'age' counts edges since its accepting edge.
   task automatic test_random(input int w, input int nops);
      logic [17:0] exp_q [$];
      logic [17:0] got;
      int age    = 0;
      int done   = 0;
      int budget = nops * (w + 2) * 8 + 1000;
      sel       = w;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      while (done < nops && budget > 0) begin
         @(negedge clk);
         budget--;
         tests_run += 2;
         if (obs_ready !== (exp_q.size() == 0)) begin
            tests_failed++;
            $display("[TB] FAIL rand_w%0d_in_ready: got %b want %b", w, obs_ready, exp_q.size() == 0);
         end
         if (obs_valid !== (exp_q.size() != 0 && age >= w)) begin
            tests_failed++;
            $display("[TB] FAIL rand_w%0d_out_valid: got %b want %b", w, obs_valid, exp_q.size() != 0 && age >= w);
         end
         if (exp_q.size() != 0 && age >= w) begin
            got = {obs_ovf, obs_cout, obs_sum};
            tests_run++;
            if (got !== exp_q[0]) begin
               tests_failed++;
               $display("[TB] FAIL rand_w%0d_result: got {ovf,cout,sum}=%h want %h", w, got, exp_q[0]);
            end
         end
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         a_in      = 16'($urandom);
         b_in      = 16'($urandom);
         cin       = 1'($urandom_range(0, 1));
         if (exp_q.size() == 0) begin
            if (in_valid) begin
               exp_q.push_back(model(w, a_in, b_in, cin));
               age = 0;
            end
         end else if (age >= w && out_ready) begin
            void'(exp_q.pop_front());
            done++;
         end else if (age < w) begin
            age++;
         end
      end
      tests_run++;
      if (done < nops) begin
         tests_failed++;
         $display("[TB] FAIL rand_w%0d_budget: completed %0d ops, required %0d", w, done, nops);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (w + 4) @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      cin       = 1'b0;
      a_in      = '0;
      b_in      = '0;
      sel       = 8;
      test_reset();
      test_basic_and_wrap();
      test_backpressure();
      test_reset_mid_run();
      test_random(8, 1000);
      test_random(1, 500);
      test_random(16, 500);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
